tlul_host_arbiter: RTL and testbench



---
 rtl/tlul_host_arbiter_pkg.sv | 34 +++
 rtl/tlul_pkg.sv | 46 ++++
 rtl/tlul_rr_pick.sv | 24 ++
 rtl/tlul_host_arbiter.sv | 110 +++++++++++
 tb/tb_tlul_host_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tlul_host_arbiter_pkg.sv
// Shared types and the round-robin search used by the TL-UL host arbiter.
package tlul_host_arbiter_pkg;

    localparam int unsigned MaxHosts = 8;
    localparam int unsigned MaxIdxW  = $clog2(MaxHosts);

    typedef logic [1:0] arb_state_e;
    localparam arb_state_e StIdle    = 2'd0;
    localparam arb_state_e StGrant   = 2'd1;
    localparam arb_state_e StWaitRsp = 2'd2;

    typedef struct packed {
        logic               any;
        logic [MaxIdxW-1:0] idx;
    } rr_pick_t;

    // First requester strictly after ptr, wrapping; ptr itself is checked last.
    function automatic rr_pick_t rr_next(input logic [MaxHosts-1:0] req,
                                         input logic [MaxIdxW-1:0]  ptr);
        rr_pick_t           res;
        logic [MaxIdxW-1:0] idx;
        res = '0;
        // Walk the ring backwards so the nearest requester is the last one written.
        for (int k = MaxHosts; k >= 1; k--) begin
            idx = ptr + MaxIdxW'(k);
            if (req[idx]) begin
                res.any = 1'b1;
                res.idx = idx;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/tlul_pkg.sv
// Minimal TL-UL channel types shared by the host arbiter and its neighbours.
package tlul_pkg;

    localparam logic [2:0] PutFullData    = 3'h0;
    localparam logic [2:0] PutPartialData = 3'h1;
    localparam logic [2:0] Get            = 3'h4;
    localparam logic [2:0] AccessAck      = 3'h0;
    localparam logic [2:0] AccessAckData  = 3'h1;

    typedef struct packed {
        logic [6:0] cmd_intg;
        logic [6:0] data_intg;
    } tl_a_user_t;

    typedef struct packed {
        logic [6:0] rsp_intg;
        logic [6:0] data_intg;
    } tl_d_user_t;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        tl_a_user_t  a_user;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        tl_d_user_t  d_user;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/tlul_rr_pick.sv
// Combinational round-robin picker: lowest-distance requester after ptr_i.
module tlul_rr_pick
    import tlul_host_arbiter_pkg::*;
#(
    parameter int unsigned NumHosts = 4
) (
    input  logic [NumHosts-1:0]         req_i,
    input  logic [$clog2(NumHosts)-1:0] ptr_i,
    output logic [$clog2(NumHosts)-1:0] gnt_idx_o,
    output logic                        any_o
);

    localparam int unsigned IdxW = $clog2(NumHosts);

    rr_pick_t pick;

    // Zero-padded requests make the mod-MaxHosts scan match a mod-NumHosts scan.
    always_comb begin
        pick      = rr_next(MaxHosts'(req_i), MaxIdxW'(ptr_i));
        any_o     = pick.any;
        gnt_idx_o = IdxW'(pick.idx);
    end

endmodule

// File: rtl/tlul_host_arbiter.sv
// Shares one TL-UL device port among NumHosts hosts, one transaction in flight.
module tlul_host_arbiter
    import tlul_host_arbiter_pkg::*;
#(
    parameter int unsigned NumHosts = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  tlul_pkg::tl_h2d_t tl_h_i [NumHosts],
    output tlul_pkg::tl_d2h_t tl_h_o [NumHosts],
    output tlul_pkg::tl_h2d_t tl_d_o,
    input  tlul_pkg::tl_d2h_t tl_d_i
);

    localparam int unsigned IdxW = $clog2(NumHosts);

    arb_state_e          state_q, state_d;
    logic [IdxW-1:0]     gnt_q, gnt_d;
    logic [IdxW-1:0]     ptr_q, ptr_d;
    logic [IdxW-1:0]     pick_idx;
    logic                pick_any;
    logic [NumHosts-1:0] req;

    // Collect A-channel requests for the picker.
    always_comb begin
        req = '0;
        for (int i = 0; i < NumHosts; i++) begin
            req[i] = tl_h_i[i].a_valid;
        end
    end

    tlul_rr_pick #(
        .NumHosts(NumHosts)
    ) u_pick (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .gnt_idx_o(pick_idx),
        .any_o    (pick_any)
    );

    // Arbitration only moves in idle; the pointer advances on a completed response.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        case (state_q)
            StIdle: begin
                if (pick_any) begin
                    state_d = StGrant;
                    gnt_d   = pick_idx;
                end
            end
            StGrant: begin
                // A winner that withdraws its request forfeits without moving the pointer.
                if (!tl_h_i[gnt_q].a_valid) begin
                    state_d = StIdle;
                end else if (tl_d_i.a_ready) begin
                    state_d = StWaitRsp;
                end
            end
            StWaitRsp: begin
                if (tl_d_i.d_valid && tl_h_i[gnt_q].d_ready) begin
                    state_d = StIdle;
                    ptr_d   = gnt_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A/D steering: only the granted host ever sees handshake strobes.
    always_comb begin
        tl_d_o = '0;
        for (int i = 0; i < NumHosts; i++) begin
            tl_h_o[i]         = tl_d_i;
            tl_h_o[i].a_ready = 1'b0;
            tl_h_o[i].d_valid = 1'b0;
        end
        case (state_q)
            StGrant: begin
                tl_d_o                = tl_h_i[gnt_q];
                tl_d_o.d_ready        = 1'b0;
                tl_h_o[gnt_q].a_ready = tl_d_i.a_ready;
            end
            StWaitRsp: begin
                tl_d_o.d_ready        = tl_h_i[gnt_q].d_ready;
                tl_h_o[gnt_q].d_valid = tl_d_i.d_valid;
            end
            default: ;
        endcase
    end

    // State registers; reset points ptr at the last host so host 0 wins first.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            ptr_q   <= IdxW'(NumHosts - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
        end
    end

    // A response with no accepted request is dropped; flag it for debug.
    a_spurious_d: assert property (@(posedge clk_i) disable iff (rst_i)
        tl_d_i.d_valid |-> (state_q == StWaitRsp));

endmodule

// File: tb/tb_tlul_host_arbiter.sv
// Scoreboard bench for tlul_host_arbiter with a single-outstanding bridge model.
module tb_tlul_host_arbiter;
    import tlul_pkg::*;

    localparam int unsigned NumHosts = 4;

    logic    clk_i = 1'b0;
    logic    rst_i;
    tl_h2d_t tl_h_i [NumHosts];
    tl_d2h_t tl_h_o [NumHosts];
    tl_h2d_t tl_d_o;
    tl_d2h_t tl_d_i;

    always #5 clk_i = ~clk_i;

    tlul_host_arbiter #(
        .NumHosts(NumHosts)
    ) u_dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .tl_h_i(tl_h_i),
        .tl_h_o(tl_h_o),
        .tl_d_o(tl_d_o),
        .tl_d_i(tl_d_i)
    );

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] addr;
    } req_t;

    typedef struct packed {
        logic [7:0]  host;
        logic [31:0] addr;
    } exp_t;

    req_t                hq [NumHosts][$];
    exp_t                exp_q [$];
    logic [NumHosts-1:0] hs_a = '0;
    logic [NumHosts-1:0] host_dready;
    int unsigned         n_vec = 0;
    int unsigned         n_err = 0;
    int unsigned         done_cnt [NumHosts];

    // Bridge model state
    logic        br_ready;
    logic        br_dv = 1'b0;
    logic [7:0]  br_src = '0;
    logic [31:0] br_data = '0;
    logic [2:0]  br_op = '0;

    function automatic logic [31:0] rsp_data(input logic [31:0] a);
        return (a == 32'h8000_0010) ? 32'hDEAD_BEEF : ~a;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs_vec();
        logic [31:0] v;
        v    = '0;
        v[0] = tl_d_o.a_valid;
        v[1] = tl_d_o.d_ready;
        for (int i = 0; i < NumHosts; i++) begin
            v[2 + i]            = tl_h_o[i].a_ready;
            v[2 + NumHosts + i] = tl_h_o[i].d_valid;
        end
        return v;
    endfunction

    // Bridge: accept one A beat, answer next cycle, hold d_valid until taken.
    always @(posedge clk_i) begin
        if (rst_i) begin
            br_dv <= 1'b0;
        end else if (br_dv) begin
            if (tl_d_o.d_ready) br_dv <= 1'b0;
        end else if (tl_d_o.a_valid && tl_d_i.a_ready) begin
            br_dv   <= 1'b1;
            br_src  <= tl_d_o.a_source;
            br_data <= rsp_data(tl_d_o.a_address);
            br_op   <= (tl_d_o.a_opcode == Get) ? AccessAckData : AccessAck;
        end
    end

    always_comb begin
        tl_d_i          = '0;
        tl_d_i.a_ready  = br_ready;
        tl_d_i.d_valid  = br_dv;
        tl_d_i.d_opcode = br_op;
        tl_d_i.d_source = br_src;
        tl_d_i.d_data   = br_data;
    end

    always @(negedge clk_i) begin
        for (int i = 0; i < NumHosts; i++) begin
            hs_a[i] <= tl_h_i[i].a_valid && tl_h_o[i].a_ready;
        end
    end

    // Scoreboard: A beats and D responses are checked against the expected-order queue.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (tl_d_o.a_valid && tl_d_i.a_ready) begin
                check_eq("a_pending", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    check_eq("a_src", 32'(tl_d_o.a_source), 32'(exp_q[0].host));
                    check_eq("a_addr", tl_d_o.a_address, exp_q[0].addr);
                end
            end
            for (int i = 0; i < NumHosts; i++) begin
                if (tl_h_o[i].d_valid) begin
                    check_eq("d_pending", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        check_eq("d_host", 32'(i), 32'(exp_q[0].host));
                        if (tl_h_i[i].d_ready) begin
                            check_eq("d_data", tl_h_o[i].d_data, rsp_data(exp_q[0].addr));
                            done_cnt[i]++;
                            exp_q.delete(0);
                        end
                    end
                end
            end
        end
    end

    task automatic host_apply(input int i);
        tl_h_i[i]          = '0;
        tl_h_i[i].d_ready  = host_dready[i];
        tl_h_i[i].a_source = 8'(i);
        if (hq[i].size() != 0) begin
            tl_h_i[i].a_valid   = 1'b1;
            tl_h_i[i].a_opcode  = hq[i][0].op;
            tl_h_i[i].a_address = hq[i][0].addr;
            tl_h_i[i].a_data    = ~hq[i][0].addr;
            tl_h_i[i].a_mask    = 4'hF;
            tl_h_i[i].a_size    = 2'd2;
            tl_h_i[i].a_user    = 14'(hq[i][0].addr);
        end
    endtask

    task automatic issue(input int h, input logic [2:0] op, input logic [31:0] addr);
        hq[h].push_back('{op: op, addr: addr});
        host_apply(h);
    endtask

    task automatic expect_txn(input int h, input logic [31:0] addr);
        exp_q.push_back('{host: 8'(h), addr: addr});
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        for (int i = 0; i < NumHosts; i++) begin
            if (hs_a[i] && hq[i].size() != 0) hq[i].delete(0);
            host_apply(i);
        end
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check_eq({tag, "_done"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        tick();
        tick();
    endtask

    task automatic wait_dvalid(input string tag, input int h);
        int n;
        n = 0;
        @(negedge clk_i);
        while (!tl_h_o[h].d_valid && n < 20) begin
            tick();
            @(negedge clk_i);
            n++;
        end
        check_eq(tag, 32'(tl_h_o[h].d_valid), 32'd1);
    endtask

    task automatic reset_dut();
        rst_i = 1'b1;
        tick();
        tick();
        @(negedge clk_i);
        check_eq("rst_outs", outs_vec(), 32'd0);
        tick();
        rst_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        br_ready    = 1'b1;
        host_dready = '1;
        rst_i       = 1'b1;
        for (int i = 0; i < NumHosts; i++) begin
            done_cnt[i] = 0;
            host_apply(i);
        end
        reset_dut();

        // Single host Get: grant visible one cycle after the request is sampled.
        expect_txn(2, 32'h8000_0010);
        issue(2, Get, 32'h8000_0010);
        @(negedge clk_i);
        check_eq("lat_n", 32'(tl_d_o.a_valid), 32'd0);
        tick();
        @(negedge clk_i);
        check_eq("lat_n1", 32'(tl_d_o.a_valid), 32'd1);
        check_eq("lat_src", 32'(tl_d_o.a_source), 32'd2);
        wait_idle("single", 20);
        check_eq("single_cnt", done_cnt[2], 32'd1);
        @(negedge clk_i);
        check_eq("single_idle", outs_vec(), 32'd0);

        // Fairness: every host always requesting, grants rotate from host 0.
        reset_dut();
        for (int i = 0; i < NumHosts; i++) done_cnt[i] = 0;
        for (int r = 0; r < 2; r++) begin
            for (int h = 0; h < NumHosts; h++) begin
                expect_txn(h, 32'h1000_0000 + 32'(h * 256 + r * 4));
            end
        end
        for (int h = 0; h < NumHosts; h++) begin
            for (int r = 0; r < 2; r++) begin
                issue(h, PutFullData, 32'h1000_0000 + 32'(h * 256 + r * 4));
            end
        end
        wait_idle("fair", 200);
        for (int h = 0; h < NumHosts; h++) begin
            check_eq("fair_cnt", done_cnt[h], 32'd2);
        end

        // Backpressure: A beat held stable, no regrant while the bridge stalls.
        br_ready = 1'b0;
        expect_txn(1, 32'h2000_0040);
        issue(1, Get, 32'h2000_0040);
        tick();
        expect_txn(0, 32'h2000_0080);
        issue(0, Get, 32'h2000_0080);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            check_eq("bp_valid", 32'(tl_d_o.a_valid), 32'd1);
            check_eq("bp_src", 32'(tl_d_o.a_source), 32'd1);
            check_eq("bp_addr", tl_d_o.a_address, 32'h2000_0040);
            check_eq("bp_h0_rdy", 32'(tl_h_o[0].a_ready), 32'd0);
            tick();
        end
        br_ready = 1'b1;
        tick();
        @(negedge clk_i);
        check_eq("bp_wait_av", 32'(tl_d_o.a_valid), 32'd0);
        check_eq("bp_wait_dv", 32'(tl_h_o[1].d_valid), 32'd1);
        wait_idle("bp", 40);

        // D stall: host 3 withholds d_ready, response held in WAIT_RSP.
        for (int i = 0; i < NumHosts; i++) done_cnt[i] = 0;
        host_dready[3] = 1'b0;
        expect_txn(3, 32'h3000_000C);
        issue(3, Get, 32'h3000_000C);
        wait_dvalid("ds_seen", 3);
        for (int k = 0; k < 3; k++) begin
            if (k != 0) @(negedge clk_i);
            check_eq("ds_dready", 32'(tl_d_o.d_ready), 32'd0);
            check_eq("ds_dvalid", 32'(tl_h_o[3].d_valid), 32'd1);
            check_eq("ds_aval", 32'(tl_d_o.a_valid), 32'd0);
            tick();
        end
        host_dready[3] = 1'b1;
        host_apply(3);
        wait_idle("ds", 20);
        check_eq("ds_cnt", done_cnt[3], 32'd1);

        // Request during response: host 1 granted two cycles after host 0's D handshake.
        host_dready[0] = 1'b0;
        expect_txn(0, 32'h4000_0000);
        issue(0, Get, 32'h4000_0000);
        wait_dvalid("rdr_seen", 0);
        tick();
        expect_txn(1, 32'h4000_0100);
        issue(1, PutFullData, 32'h4000_0100);
        @(negedge clk_i);
        check_eq("rdr_hold", 32'(tl_d_o.a_valid), 32'd0);
        tick();
        host_dready[0] = 1'b1;
        host_apply(0);
        @(negedge clk_i);
        check_eq("rdr_hs", 32'(tl_h_o[0].d_valid && tl_d_o.d_ready), 32'd1);
        tick();
        @(negedge clk_i);
        check_eq("rdr_gap", 32'(tl_d_o.a_valid), 32'd0);
        tick();
        @(negedge clk_i);
        check_eq("rdr_gnt", 32'(tl_d_o.a_valid), 32'd1);
        check_eq("rdr_src", 32'(tl_d_o.a_source), 32'd1);
        wait_idle("rdr", 20);

        // Reset mid-transaction: response dropped, host 0 wins the next tie with host 3.
        host_dready[2] = 1'b0;
        expect_txn(2, 32'h5000_0020);
        issue(2, Get, 32'h5000_0020);
        wait_dvalid("mr_seen", 2);
        tick();
        rst_i = 1'b1;
        tick();
        @(negedge clk_i);
        check_eq("mr_outs", outs_vec(), 32'd0);
        exp_q.delete();
        tick();
        rst_i          = 1'b0;
        host_dready[2] = 1'b1;
        host_apply(2);
        @(negedge clk_i);
        check_eq("mr_quiet", outs_vec(), 32'd0);
        tick();
        expect_txn(0, 32'h6000_0000);
        expect_txn(3, 32'h6000_0300);
        issue(0, Get, 32'h6000_0000);
        issue(3, Get, 32'h6000_0300);
        tick();
        @(negedge clk_i);
        check_eq("mr_gnt_src", 32'(tl_d_o.a_source), 32'd0);
        wait_idle("mr", 40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
